// File: rtl/cc_mem_port_arbiter_if.sv
// Bus bundle between the two cache refill engines, the arbiter and the memory bridge.
// slave is the arbiter's view; master is the environment (requesters plus memory) view.
interface cc_mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_req_ready;
    logic                  d_req_valid;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic                  d_req_we;
    logic                  d_req_ready;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_wready;
    logic                  d_wdone;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  i_rvalid;
    logic                  d_rvalid;
    logic                  rsp_last;
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_we;
    logic                  mem_req_ready;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wvalid;
    logic                  mem_wready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rvalid;
    logic                  mem_bvalid;

    modport slave (
        input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, d_wdata,
               mem_req_ready, mem_wready, mem_rdata, mem_rvalid, mem_bvalid,
        output i_req_ready, d_req_ready, d_wready, d_wdone, rsp_rdata, i_rvalid,
               d_rvalid, rsp_last, mem_req_valid, mem_req_addr, mem_req_we,
               mem_wdata, mem_wvalid
    );

    modport master (
        output i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, d_wdata,
               mem_req_ready, mem_wready, mem_rdata, mem_rvalid, mem_bvalid,
        input  i_req_ready, d_req_ready, d_wready, d_wdone, rsp_rdata, i_rvalid,
               d_rvalid, rsp_last, mem_req_valid, mem_req_addr, mem_req_we,
               mem_wdata, mem_wvalid
    );
endinterface

// File: rtl/cc_mem_port_arbiter.sv
// Round-robin arbiter sharing one line-burst memory port between the I-cache refill
// engine and the D-cache refill/writeback engine.
module cc_mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input logic clk,
    input logic reset,
    cc_mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic                  owner_d;
    logic                  last_grant_d;
    logic                  grant_i, grant_d, beat_done;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Outputs are forced low while reset is high so an aborted burst forwards nothing.
    always_comb begin
        state_nxt         = state;
        grant_i           = 1'b0;
        grant_d           = 1'b0;
        beat_done         = 1'b0;
        bus.i_req_ready   = 1'b0;
        bus.d_req_ready   = 1'b0;
        bus.d_wready      = 1'b0;
        bus.d_wdone       = 1'b0;
        bus.rsp_rdata     = '0;
        bus.i_rvalid      = 1'b0;
        bus.d_rvalid      = 1'b0;
        bus.rsp_last      = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_we    = 1'b0;
        bus.mem_wdata     = '0;
        bus.mem_wvalid    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (bus.i_req_valid && (!bus.d_req_valid || last_grant_d)) grant_i = 1'b1;
                    else if (bus.d_req_valid)                                   grant_d = 1'b1;
                    bus.i_req_ready = grant_i;
                    bus.d_req_ready = grant_d;
                    if (grant_i || grant_d) state_nxt = ADDR;
                end
                ADDR: begin
                    bus.mem_req_valid = 1'b1;
                    bus.mem_req_addr  = addr_q & ~LINE_MASK;
                    bus.mem_req_we    = we_q;
                    if (bus.mem_req_ready) state_nxt = we_q ? WDATA : RDATA;
                end
                RDATA: begin
                    if (bus.mem_rvalid) begin
                        bus.rsp_rdata = bus.mem_rdata;
                        bus.i_rvalid  = !owner_d;
                        bus.d_rvalid  = owner_d;
                        bus.rsp_last  = (beat_cnt == LAST_BEAT);
                        beat_done     = 1'b1;
                        if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
                    end
                end
                WDATA: begin
                    bus.mem_wvalid = 1'b1;
                    bus.mem_wdata  = bus.d_wdata;
                    bus.d_wready   = bus.mem_wready;
                    if (bus.mem_wready) begin
                        beat_done = 1'b1;
                        if (beat_cnt == LAST_BEAT) state_nxt = WRESP;
                    end
                end
                WRESP: begin
                    if (bus.mem_bvalid) begin
                        bus.d_wdone = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            owner_d      <= 1'b0;
            last_grant_d <= 1'b1;
        end else begin
            if (grant_i) begin
                addr_q  <= bus.i_req_addr;
                we_q    <= 1'b0;
                owner_d <= 1'b0;
            end else if (grant_d) begin
                addr_q  <= bus.d_req_addr;
                we_q    <= bus.d_req_we;
                owner_d <= 1'b1;
            end
            if (beat_done) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            if (state == RDATA && beat_done && beat_cnt == LAST_BEAT) last_grant_d <= owner_d;
            if (state == WRESP && bus.mem_bvalid) last_grant_d <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cc_mem_port_arbiter.sv
// Self-checking bench for cc_mem_port_arbiter: directed scenarios with randomized data,
// gaps and addresses checked against a simple grant/burst model.
module tb_cc_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int OW = 2 * DW + AW + 10;
    localparam logic [AW-1:0] LMASK = AW'(LW * DW / 8 - 1);

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cc_mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    cc_mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    function automatic logic [OW-1:0] outs();
        return {bus.i_req_ready, bus.d_req_ready, bus.d_wready, bus.d_wdone, bus.rsp_rdata,
                bus.i_rvalid, bus.d_rvalid, bus.rsp_last, bus.mem_req_valid, bus.mem_req_addr,
                bus.mem_req_we, bus.mem_wdata, bus.mem_wvalid};
    endfunction

    task automatic clear_inputs();
        bus.i_req_valid = 0; bus.i_req_addr = '0; bus.d_req_valid = 0; bus.d_req_addr = '0;
        bus.d_req_we = 0; bus.d_wdata = '0; bus.mem_req_ready = 0; bus.mem_wready = 0;
        bus.mem_rdata = '0; bus.mem_rvalid = 0; bus.mem_bvalid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        clear_inputs();
        bus.i_req_valid = 1; bus.d_req_valid = 1; bus.mem_rvalid = 1; bus.mem_bvalid = 1;
        @(negedge clk); #1;
        n_checks++;
        if (outs() !== '0) begin n_fail++; $display("FAIL reset_held: outs got %h expected 0", outs()); end
        @(negedge clk);
        clear_inputs();
        reset = 0;
        #1;
        n_checks++;
        if (outs() !== '0) begin n_fail++; $display("FAIL reset_idle: outs got %h expected 0", outs()); end
    endtask

    task automatic test_i_refill();
        logic [DW-1:0] exp_data [LW];
        int beat, cycles;
        for (int k = 0; k < LW; k++) exp_data[k] = DW'(32'hA0 + k);
        do_reset();
        bus.i_req_valid = 1; bus.i_req_addr = 32'h104;
        #1;
        n_checks++;
        if ({bus.i_req_ready, bus.d_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL i_grant: ready got %b expected 10", {bus.i_req_ready, bus.d_req_ready});
        end
        @(negedge clk);
        bus.i_req_valid = 0; bus.i_req_addr = $urandom;
        #1;
        n_checks++;
        if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.i_req_ready} !== {1'b1, 32'h100, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL i_addr: valid/addr/we/ready got %b/%h/%b/%b expected 1/00000100/0/0",
                               bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.i_req_ready);
        end
        bus.mem_req_ready = 1;
        @(negedge clk);
        bus.mem_req_ready = 0;
        beat = 0; cycles = 0;
        while (beat < LW && cycles < 40) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.mem_rvalid = 0; bus.mem_rdata = $urandom;
                #1;
                n_checks++;
                if ({bus.i_rvalid, bus.d_rvalid, bus.rsp_last} !== 3'b000) begin
                    n_fail++; $display("FAIL i_gap: i/d/last got %b expected 000", {bus.i_rvalid, bus.d_rvalid, bus.rsp_last});
                end
            end else begin
                bus.mem_rvalid = 1; bus.mem_rdata = exp_data[beat];
                #1;
                n_checks++;
                if ({bus.i_rvalid, bus.d_rvalid, bus.rsp_last, bus.rsp_rdata} !== {1'b1, 1'b0, beat == LW - 1, exp_data[beat]}) begin
                    n_fail++; $display("FAIL i_beat%0d: i/d/last/data got %b/%b/%b/%h expected 1/0/%b/%h", beat,
                                       bus.i_rvalid, bus.d_rvalid, bus.rsp_last, bus.rsp_rdata, beat == LW - 1, exp_data[beat]);
                end
                beat++;
            end
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (beat != LW) begin n_fail++; $display("FAIL i_beats_timeout: got %0d beats expected %0d", beat, LW); end
        bus.mem_rvalid = 0;
        #1;
        n_checks++;
        if (outs() !== '0) begin n_fail++; $display("FAIL i_end_idle: outs got %h expected 0", outs()); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] i_addr, d_addr, exp_addr;
        logic [DW-1:0] rd;
        bit last_was_i, exp_i;
        int w;
        do_reset();
        last_was_i = 0;
        i_addr = $urandom; d_addr = $urandom;
        bus.i_req_valid = 1; bus.i_req_addr = i_addr;
        bus.d_req_valid = 1; bus.d_req_addr = d_addr; bus.d_req_we = 0;
        for (int b = 0; b < 4; b++) begin
            exp_i = !last_was_i;
            #1;
            w = 0;
            while (!(bus.i_req_ready || bus.d_req_ready) && w < 8) begin @(negedge clk); #1; w++; end
            n_checks++;
            if ({bus.i_req_ready, bus.d_req_ready} !== (exp_i ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL rr_grant%0d: ready i/d got %b expected %b", b,
                                   {bus.i_req_ready, bus.d_req_ready}, exp_i ? 2'b10 : 2'b01);
                break;
            end
            exp_addr = (exp_i ? i_addr : d_addr) & ~LMASK;
            @(negedge clk);
            if (exp_i) i_addr = $urandom; else d_addr = $urandom;
            bus.i_req_addr = i_addr; bus.d_req_addr = d_addr;
            #1;
            n_checks++;
            if ({bus.i_req_ready, bus.d_req_ready, bus.mem_req_valid, bus.mem_req_addr} !== {2'b00, 1'b1, exp_addr}) begin
                n_fail++; $display("FAIL rr_pulse_addr%0d: ready/valid/addr got %b/%b/%h expected 00/1/%h", b,
                                   {bus.i_req_ready, bus.d_req_ready}, bus.mem_req_valid, bus.mem_req_addr, exp_addr);
            end
            bus.mem_req_ready = 1;
            @(negedge clk);
            bus.mem_req_ready = 0;
            for (int k = 0; k < LW; k++) begin
                rd = $urandom;
                bus.mem_rvalid = 1; bus.mem_rdata = rd;
                #1;
                n_checks++;
                if ({bus.i_rvalid, bus.d_rvalid, bus.rsp_last, bus.rsp_rdata} !== {exp_i, !exp_i, k == LW - 1, rd}) begin
                    n_fail++; $display("FAIL rr_beat%0d_%0d: i/d/last/data got %b/%b/%b/%h expected %b/%b/%b/%h", b, k,
                                       bus.i_rvalid, bus.d_rvalid, bus.rsp_last, bus.rsp_rdata, exp_i, !exp_i, k == LW - 1, rd);
                end
                @(negedge clk);
            end
            bus.mem_rvalid = 0;
            last_was_i = exp_i;
        end
        bus.i_req_valid = 0; bus.d_req_valid = 0;
    endtask

    task automatic test_writeback();
        logic [DW-1:0] wd [4];
        logic          pat [6];
        int b;
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 1;
        do_reset();
        bus.d_req_valid = 1; bus.d_req_we = 1; bus.d_req_addr = 32'h2008;
        #1;
        n_checks++;
        if ({bus.i_req_ready, bus.d_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL wb_grant: ready i/d got %b expected 01", {bus.i_req_ready, bus.d_req_ready});
        end
        @(negedge clk);
        bus.d_req_valid = 0;
        #1;
        n_checks++;
        if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we} !== {1'b1, 32'h2000, 1'b1}) begin
            n_fail++; $display("FAIL wb_addr: valid/addr/we got %b/%h/%b expected 1/00002000/1",
                               bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we);
        end
        bus.mem_req_ready = 1;
        @(negedge clk);
        bus.mem_req_ready = 0;
        b = 0;
        for (int j = 0; j < 6; j++) begin
            bus.d_wdata = wd[b]; bus.mem_wready = pat[j];
            #1;
            n_checks++;
            if ({bus.mem_wvalid, bus.mem_wdata, bus.d_wready, bus.d_wdone} !== {1'b1, wd[b], pat[j], 1'b0}) begin
                n_fail++; $display("FAIL wb_beat%0d: wvalid/wdata/wready/done got %b/%h/%b/%b expected 1/%h/%b/0", j,
                                   bus.mem_wvalid, bus.mem_wdata, bus.d_wready, bus.d_wdone, wd[b], pat[j]);
            end
            if (pat[j]) b++;
            @(negedge clk);
        end
        bus.mem_wready = 0; bus.mem_bvalid = 0;
        #1;
        n_checks++;
        if ({bus.mem_wvalid, bus.d_wdone, bus.mem_req_valid} !== 3'b000) begin
            n_fail++; $display("FAIL wb_wait_resp: wvalid/done/req got %b expected 000", {bus.mem_wvalid, bus.d_wdone, bus.mem_req_valid});
        end
        @(negedge clk);
        bus.mem_bvalid = 1;
        #1;
        n_checks++;
        if (bus.d_wdone !== 1'b1) begin n_fail++; $display("FAIL wb_done: d_wdone got %b expected 1", bus.d_wdone); end
        @(negedge clk);
        bus.mem_bvalid = 0;
        #1;
        n_checks++;
        if (outs() !== '0) begin n_fail++; $display("FAIL wb_end_idle: outs got %h expected 0", outs()); end
    endtask

    task automatic test_req_stall();
        do_reset();
        bus.i_req_valid = 1; bus.i_req_addr = 32'h44;
        @(negedge clk);
        bus.i_req_valid = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin bus.i_req_valid = 1; bus.i_req_addr = 32'h80; end
            bus.mem_req_ready = (c == 5);
            #1;
            n_checks++;
            if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.i_req_ready} !== {1'b1, 32'h40, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold%0d: valid/addr/we/ready got %b/%h/%b/%b expected 1/00000040/0/0", c,
                                   bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.i_req_ready);
            end
            @(negedge clk);
        end
        bus.mem_req_ready = 0;
        for (int k = 0; k < LW; k++) begin
            bus.mem_rvalid = 1; bus.mem_rdata = $urandom;
            #1;
            n_checks++;
            if ({bus.i_req_ready, bus.i_rvalid} !== 2'b01) begin
                n_fail++; $display("FAIL stall_beat%0d: ready/rvalid got %b expected 01", k, {bus.i_req_ready, bus.i_rvalid});
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 0;
        #1;
        n_checks++;
        if (bus.i_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_regrant: i_req_ready got %b expected 1", bus.i_req_ready); end
        @(negedge clk);
        bus.i_req_valid = 0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.i_req_valid = 1; bus.i_req_addr = 32'h500;
        @(negedge clk);
        bus.i_req_valid = 0; bus.mem_req_ready = 1;
        @(negedge clk);
        bus.mem_req_ready = 0;
        for (int k = 0; k < 2; k++) begin
            bus.mem_rvalid = 1; bus.mem_rdata = $urandom;
            @(negedge clk);
        end
        reset = 1; bus.mem_rdata = $urandom;
        @(negedge clk);
        reset = 0; bus.mem_bvalid = 1;
        #1;
        n_checks++;
        if (outs() !== '0) begin n_fail++; $display("FAIL abort_outs: outs got %h expected 0", outs()); end
        @(negedge clk);
        bus.mem_rvalid = 0; bus.mem_bvalid = 0;
        bus.d_req_valid = 1; bus.d_req_we = 0; bus.d_req_addr = 32'h300;
        #1;
        n_checks++;
        if ({bus.i_req_ready, bus.d_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL abort_dgrant: ready i/d got %b expected 01", {bus.i_req_ready, bus.d_req_ready});
        end
        @(negedge clk);
        bus.d_req_valid = 0;
        #1;
        n_checks++;
        if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we} !== {1'b1, 32'h300, 1'b0}) begin
            n_fail++; $display("FAIL abort_daddr: valid/addr/we got %b/%h/%b expected 1/00000300/0",
                               bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we);
        end
        bus.mem_req_ready = 1;
        @(negedge clk);
        bus.mem_req_ready = 0;
        for (int k = 0; k < LW; k++) begin
            bus.mem_rvalid = 1; bus.mem_rdata = $urandom;
            #1;
            n_checks++;
            if ({bus.i_rvalid, bus.d_rvalid, bus.rsp_last} !== {2'b01, k == LW - 1}) begin
                n_fail++; $display("FAIL abort_dbeat%0d: i/d/last got %b expected 01%b", k,
                                   {bus.i_rvalid, bus.d_rvalid, bus.rsp_last}, k == LW - 1);
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 0;
    endtask

    task automatic test_idle_ignore();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            bus.mem_rvalid = 1; bus.mem_bvalid = 1; bus.mem_rdata = $urandom;
            #1;
            n_checks++;
            if ({bus.i_rvalid, bus.d_rvalid, bus.rsp_last, bus.d_wdone, bus.rsp_rdata} !== '0) begin
                n_fail++; $display("FAIL idle_ignore%0d: i/d/last/done got %b expected 0000", c,
                                   {bus.i_rvalid, bus.d_rvalid, bus.rsp_last, bus.d_wdone});
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 0; bus.mem_bvalid = 0;
        bus.i_req_valid = 1; bus.i_req_addr = $urandom;
        @(negedge clk);
        bus.i_req_valid = 0; bus.mem_req_ready = 1;
        @(negedge clk);
        bus.mem_req_ready = 0;
        for (int k = 0; k < LW; k++) begin
            bus.mem_rvalid = 1; bus.mem_rdata = $urandom;
            #1;
            n_checks++;
            if ({bus.i_rvalid, bus.rsp_last} !== {1'b1, k == LW - 1}) begin
                n_fail++; $display("FAIL idle_then_beat%0d: rvalid/last got %b expected 1%b", k,
                                   {bus.i_rvalid, bus.rsp_last}, k == LW - 1);
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_i_refill();
        test_round_robin();
        test_writeback();
        test_req_stall();
        test_reset_mid_burst();
        test_idle_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
